// File: rtl/acc_ctrl_pkg.sv
// Shared types and helpers for the accumulator-sharing scheduler.
// Holds the FSM encoding, default widths and the width helpers.
package acc_ctrl_pkg;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 12;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_RUN    = 3'd2,
    S_DRAIN1 = 3'd3,
    S_DRAIN2 = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  function automatic int clog2(input int v);
    int r;
    int t;
    r = 0;
    t = v - 1;
    while (t > 0) begin
      r++;
      t = t >> 1;
    end
    return r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int v);
    int r;
    r = clog2(v);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/acc_share_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping modulo N_REQ. The pointer register lives in the caller.
module rr_arbiter
  import acc_ctrl_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  logic [IW:0] p;

  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    p     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      p = {1'b0, i_ptr} + (IW+1)'(i);
      if (p >= (IW+1)'(N_REQ)) begin
        p = p - (IW+1)'(N_REQ);
      end
      if (!o_any && i_req[p[IW-1:0]]) begin
        o_any = 1'b1;
        o_idx = p[IW-1:0];
      end
    end
  end

  always_comb begin
    o_gnt = '0;
    if (o_any) begin
      o_gnt = N_REQ'(1) << o_idx;
    end
  end

endmodule

// File: rtl/acc_share_ctrl.sv
// Time-shares one external accumulator between N_REQ sample sources,
// one frame of FRAME_LEN samples per grant, round-robin.
module acc_share_ctrl
  import acc_ctrl_pkg::*;
#(
  parameter  int N_REQ     = 2,
  parameter  int DW        = DW_DEF,
  parameter  int AW        = AW_DEF,
  parameter  int FRAME_LEN = 8,
  localparam int IW        = idx_w(N_REQ),
  localparam int CW        = idx_w(FRAME_LEN)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_REQ-1:0]      i_req_valid,
  input  logic [N_REQ*DW-1:0]   i_req_x,
  output logic [N_REQ-1:0]      o_req_ready,
  output logic                  o_acc_clr,
  output logic                  o_acc_valid,
  output logic [DW-1:0]         o_acc_x,
  input  logic [AW-1:0]         i_acc,
  output logic                  o_res_valid,
  output logic [AW-1:0]         o_res_data,
  output logic [IW-1:0]         o_res_id,
  input  logic                  i_res_ready,
  output logic                  o_busy
);

  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
  localparam logic [IW-1:0] TOP  = IW'(N_REQ - 1);

  state_e            state_q, state_d;
  logic [IW-1:0]     gnt_q, gnt_d;
  logic [N_REQ-1:0]  gnt_oh_q, gnt_oh_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     acc_x_q, acc_x_d;
  logic              acc_vld_q, acc_vld_d;
  logic [AW-1:0]     res_data_q, res_data_d;
  logic [IW-1:0]     res_id_q, res_id_d;

  logic [N_REQ-1:0]  arb_gnt;
  logic [IW-1:0]     arb_idx;
  logic              arb_any;
  logic [DW-1:0]     g_x;
  logic              g_v;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .i_req (i_req_valid),
    .i_ptr (ptr_q),
    .o_gnt (arb_gnt),
    .o_idx (arb_idx),
    .o_any (arb_any)
  );

  // Sample/valid of the currently granted requester.
  always_comb begin
    g_x = '0;
    g_v = 1'b0;
    for (int r = 0; r < N_REQ; r++) begin
      if (gnt_q == IW'(r)) begin
        g_x = i_req_x[r*DW +: DW];
        g_v = i_req_valid[r];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_oh_d    = gnt_oh_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    acc_x_d     = acc_x_q;
    acc_vld_d   = 1'b0;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    o_req_ready = '0;
    o_acc_clr   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          gnt_d    = arb_idx;
          gnt_oh_d = arb_gnt;
          state_d  = S_CLR;
        end
      end
      S_CLR: begin
        o_acc_clr = 1'b1;
        cnt_d     = '0;
        state_d   = S_RUN;
      end
      S_RUN: begin
        o_req_ready = gnt_oh_q;
        if (g_v) begin
          acc_x_d   = g_x;
          acc_vld_d = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = S_DRAIN1;
          end
        end
      end
      S_DRAIN1: begin
        state_d = S_DRAIN2;
      end
      S_DRAIN2: begin
        res_data_d = i_acc;
        res_id_d   = gnt_q;
        state_d    = S_DONE;
      end
      S_DONE: begin
        if (i_res_ready) begin
          ptr_d   = (gnt_q == TOP) ? '0 : gnt_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      gnt_oh_q   <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      acc_x_q    <= '0;
      acc_vld_q  <= 1'b0;
      res_data_q <= '0;
      res_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_oh_q   <= gnt_oh_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      acc_x_q    <= acc_x_d;
      acc_vld_q  <= acc_vld_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
    end
  end

  assign o_acc_valid = acc_vld_q;
  assign o_acc_x     = acc_x_q;
  assign o_res_valid = (state_q == S_DONE);
  assign o_res_data  = res_data_q;
  assign o_res_id    = res_id_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_acc_share_ctrl.sv
// Bench for acc_share_ctrl: external accumulator model, frame-level
// reference model, per-cycle compare and directed + random stimulus.
module tb_acc_share_ctrl;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int AW = 12;
  localparam int FL = 8;
  localparam int IW = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_x;
  logic [N-1:0]      req_ready;
  logic              acc_clr;
  logic              acc_valid;
  logic [DW-1:0]     acc_x;
  logic [AW-1:0]     acc = '0;
  logic              res_valid;
  logic [AW-1:0]     res_data;
  logic [IW-1:0]     res_id;
  logic              res_ready;
  logic              busy;

  always #5 clk = ~clk;

  acc_share_ctrl #(
    .N_REQ     (N),
    .DW        (DW),
    .AW        (AW),
    .FRAME_LEN (FL)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .i_req_x     (req_x),
    .o_req_ready (req_ready),
    .o_acc_clr   (acc_clr),
    .o_acc_valid (acc_valid),
    .o_acc_x     (acc_x),
    .i_acc       (acc),
    .o_res_valid (res_valid),
    .o_res_data  (res_data),
    .o_res_id    (res_id),
    .i_res_ready (res_ready),
    .o_busy      (busy)
  );

  // External accumulator instance
  always @(posedge clk) begin
    if (acc_clr) acc <= '0;
    else if (acc_valid) acc <= acc + {{(AW-DW){acc_x[DW-1]}}, acc_x};
  end

  int errors = 0;
  int checks = 0;
  int clr_cnt = 0;
  int tx_cnt = 0;
  int q_id[$];
  logic [AW-1:0] q_data[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: frame phases 0 idle, 1 clear, 2 stream,
  // 3 pipeline tail, 4 result held.
  int            m_stage = 0;
  int            m_g = 0;
  int            m_n = 0;
  int            m_tail = 0;
  int            m_ptr = 0;
  int            m_rid = 0;
  int            m_results = 0;
  logic [AW-1:0] m_sum = '0;
  logic [AW-1:0] m_rdata = '0;
  logic          m_vld = 1'b0;
  logic [DW-1:0] m_x = '0;

  function automatic int rr(logic [N-1:0] v, int p);
    int k;
    for (int i = 0; i < N; i++) begin
      k = (p + i) % N;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : mdl
    logic [DW-1:0] s;
    if (rst) begin
      m_stage = 0;
      m_ptr   = 0;
      m_vld   = 1'b0;
      m_x     = '0;
      m_rdata = '0;
      m_rid   = 0;
    end else begin
      s = req_x[m_g*DW +: DW];
      m_vld = 1'b0;
      case (m_stage)
        0: if (|req_valid) begin
          m_g = rr(req_valid, m_ptr);
          m_stage = 1;
        end
        1: begin
          m_stage = 2;
          m_n = 0;
          m_sum = '0;
        end
        2: if (req_valid[m_g]) begin
          m_vld = 1'b1;
          m_x = s;
          m_sum = m_sum + {{(AW-DW){s[DW-1]}}, s};
          m_n++;
          if (m_n == FL) begin
            m_stage = 3;
            m_tail = 0;
          end
        end
        3: begin
          m_tail++;
          if (m_tail == 2) begin
            m_stage = 4;
            m_rdata = m_sum;
            m_rid = m_g;
          end
        end
        default: if (res_ready) begin
          m_ptr = (m_g + 1) % N;
          m_stage = 0;
          m_results++;
        end
      endcase
    end
  end

  // DUT-side observations: result handshakes and sample transfers
  always @(posedge clk) begin
    if (!rst && res_valid && res_ready) begin
      q_id.push_back(int'(res_id));
      q_data.push_back(res_data);
    end
    if (!rst && |(req_valid & req_ready)) tx_cnt++;
  end

  always @(negedge clk) begin : cmp
    logic [N-1:0] er;
    er = (m_stage == 2) ? N'(1) << m_g : '0;
    if (acc_clr) clr_cnt++;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("req_ready_onehot", 32'($countones(req_ready) <= 1), 1);
    chk("acc_clr", 32'(acc_clr), 32'(m_stage == 1));
    chk("acc_valid", 32'(acc_valid), 32'(m_vld));
    if (m_vld) chk("acc_x", 32'(acc_x), 32'(m_x));
    chk("busy", 32'(busy), 32'(m_stage != 0));
    chk("res_valid", 32'(res_valid), 32'(m_stage == 4));
    chk("res_data", 32'(res_data), 32'(m_rdata));
    chk("res_id", 32'(res_id), 32'(m_rid));
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_res(int i, int id, logic [AW-1:0] d);
    if (i >= q_id.size()) begin
      chk("res_missing", 0, 1);
    end else begin
      chk("res_q_id", q_id[i], id);
      chk("res_q_data", 32'(q_data[i]), 32'(d));
    end
  endtask

  task automatic wait_res(int target, int bound, string nm);
    for (int k = 0; k < bound; k++) begin
      tick(1);
      if (q_id.size() >= target) break;
    end
    chk(nm, 32'(q_id.size() >= target), 1);
  endtask

  initial begin
    int lat;
    int base;
    int tx0;
    bit seen;
    rst = 1'b1;
    req_valid = '0;
    req_x = '0;
    res_ready = 1'b1;
    tick(2);
    rst = 1'b0;

    // Single requester, continuous valid
    req_x[0*DW +: DW] = 8'd1;
    req_valid = 2'b01;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (res_valid) begin
        lat = k;
        break;
      end
    end
    chk("latency", 32'(lat), 12);
    tick(1);
    req_valid = '0;
    tick(2);
    chk("clr_pulses", 32'(clr_cnt), 1);
    chk("t1_count", 32'(q_id.size()), 1);
    chk_res(0, 0, 12'd8);

    // Round-robin contention from a fresh pointer
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    base = q_id.size();
    req_x[0*DW +: DW] = 8'd3;
    req_x[1*DW +: DW] = 8'hFE;
    req_valid = 2'b11;
    wait_res(base + 3, 200, "t2_timeout");
    req_valid = '0;
    tick(3);
    chk_res(base, 0, 12'd24);
    chk_res(base + 1, 1, 12'hFF0);
    chk_res(base + 2, 0, 12'd24);

    // Most negative sample with valid gaps
    base = q_id.size();
    req_x[1*DW +: DW] = 8'h80;
    req_valid = 2'b10;
    seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      tick(1);
      if (q_id.size() > base) begin
        seen = 1'b1;
        break;
      end
      req_valid[1] = ~req_valid[1];
    end
    chk("t3_timeout", 32'(seen), 1);
    req_valid = '0;
    tick(3);
    chk_res(base, 1, 12'hC00);

    // Result backpressure
    res_ready = 1'b0;
    base = q_id.size();
    req_x[0*DW +: DW] = 8'd5;
    req_valid = 2'b01;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick(1);
      if (res_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t4_timeout", 32'(seen), 1);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      chk("bp_valid", 32'(res_valid), 1);
      chk("bp_data", 32'(res_data), 40);
      chk("bp_id", 32'(res_id), 0);
      chk("bp_ready", 32'(req_ready), 0);
      chk("bp_clr", 32'(acc_clr), 0);
    end
    res_ready = 1'b1;
    req_valid = '0;
    tick(3);
    chk("t4_count", 32'(q_id.size()), 32'(base + 1));
    chk_res(base, 0, 12'd40);

    // Mid-frame reset
    base = q_id.size();
    tx0 = tx_cnt;
    req_x[0*DW +: DW] = 8'd7;
    req_valid = 2'b01;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick(1);
      if (tx_cnt >= tx0 + 4) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t5_timeout", 32'(seen), 1);
    rst = 1'b1;
    tick(1);
    chk("rst_acc_valid", 32'(acc_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_res_data", 32'(res_data), 0);
    rst = 1'b0;
    req_x[0*DW +: DW] = 8'd2;
    wait_res(base + 1, 200, "t5_result_timeout");
    req_valid = '0;
    tick(3);
    chk("t5_count", 32'(q_id.size()), 32'(base + 1));
    chk_res(base, 0, 12'd16);

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      tick(1);
      req_valid = N'($urandom);
      req_x = (N*DW)'($urandom);
      res_ready = ($urandom % 4) != 0;
      rst = ($urandom % 500) == 0;
    end
    rst = 1'b0;
    req_valid = '0;
    res_ready = 1'b1;
    tick(20);
    chk("result_count", 32'(q_id.size()), 32'(m_results));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
